// File: rtl/video_sched_pkg.sv
// Shared types and constants for the frame-synchronous video write scheduler.
package video_sched_pkg;

  localparam int unsigned VID_AW = 21;
  localparam int unsigned VID_DW = 32;

  // Address bit that selects frame-buffer space (bypasses the slot queue)
  localparam int unsigned FB_BIT = 20;

  typedef struct packed {
    logic [VID_AW-1:0] addr;
    logic [VID_DW-1:0] data;
  } vwr_t;

  typedef enum logic {
    WIN_CLOSED = 1'b0,
    WIN_OPEN   = 1'b1
  } win_state_t;

endpackage

// File: rtl/vsched_fifo.sv
// Synchronous FIFO for queued slot writes. Read data is the current head (show-ahead).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vsched_fifo
  import video_sched_pkg::*;
#(
  parameter int unsigned DepthLog2 = 4,
  parameter int unsigned Width     = $bits(vwr_t)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [Width-1:0]     wdata,
  input  logic                 pop,
  output logic [Width-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [DepthLog2:0]   count
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] DepthCnt = (DepthLog2 + 1)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DepthLog2'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DepthLog2 + 1)'(1);
      2'b01:   count_d = count_q - (DepthLog2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state, cleared by reset (discards queued entries)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/video_wr_scheduler.sv
// Frame-synchronous write scheduler: slot-register writes are queued and released only
// inside the vertical blanking window; frame-buffer writes bypass the queue.
module video_wr_scheduler
  import video_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AW         = VID_AW,
  parameter int unsigned DW         = VID_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_cs,
  input  logic                  video_wr,
  input  logic [AW-1:0]         video_addr,
  input  logic [DW-1:0]         video_wr_data,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  sync_en,
  input  logic                  ovf_clr,
  output logic                  out_cs,
  output logic                  out_wr,
  output logic [AW-1:0]         out_addr,
  output logic [DW-1:0]         out_wr_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  window_open
);

  win_state_t          win_q, win_d;
  logic                accept, is_fb, bypass, push_req, pop, drop;
  logic                fifo_full, fifo_empty;
  logic [AW+DW-1:0]    fifo_rdata;
  logic                ovf_q, ovf_d;
  logic                out_wr_q, out_wr_d;
  logic [AW-1:0]       out_addr_q, out_addr_d;
  logic [DW-1:0]       out_data_q, out_data_d;

  // Video space is write-only: a select without a write strobe does nothing
  assign accept = video_cs & video_wr;
  assign is_fb  = video_addr[FB_BIT];

  // Slot writes may skip the queue only when unsynchronised and nothing is waiting,
  // otherwise they would overtake older queued writes
  assign bypass   = accept & (is_fb | (~sync_en & fifo_empty));
  assign push_req = accept & ~bypass;
  assign pop      = (window_open | ~sync_en) & ~fifo_empty & ~bypass;
  assign drop     = push_req & fifo_full & ~pop;

  vsched_fifo #(
    .DepthLog2 (DEPTH_LOG2),
    .Width     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata ({video_addr, video_wr_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Blanking window: opens on frame_end, closes on frame_start (start wins on a tie)
  always_comb begin
    win_d = win_q;
    if (frame_start)    win_d = WIN_CLOSED;
    else if (frame_end) win_d = WIN_OPEN;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Output mux: bypass write has priority over a queue pop
  always_comb begin
    out_wr_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    if (bypass) begin
      out_wr_d   = 1'b1;
      out_addr_d = video_addr;
      out_data_d = video_wr_data;
    end else if (pop) begin
      out_wr_d   = 1'b1;
      out_addr_d = fifo_rdata[AW+DW-1:DW];
      out_data_d = fifo_rdata[DW-1:0];
    end
  end

  // Window state, overflow flag and registered decoder bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q      <= WIN_CLOSED;
      ovf_q      <= 1'b0;
      out_wr_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      win_q      <= win_d;
      ovf_q      <= ovf_d;
      out_wr_q   <= out_wr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign window_open = (win_q == WIN_OPEN);
  assign overflow    = ovf_q;
  assign out_cs      = out_wr_q;
  assign out_wr      = out_wr_q;
  assign out_addr    = out_addr_q;
  assign out_wr_data = out_data_q;

endmodule
